// File: rtl/mem_defs.sv
// Shared encodings for the data-memory access path: funct3 access widths,
// decoder store-source selects and the access unit's FSM state codes.
package mem_defs;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  localparam logic [1:0] MEM_WRITE_SRC_REG = 2'b01;
  localparam logic [1:0] MEM_WRITE_SRC_XMM = 2'b10;

  localparam logic [1:0] MAU_STATE_IDLE = 2'd0;
  localparam logic [1:0] MAU_STATE_REQ  = 2'd1;
  localparam logic [1:0] MAU_STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MAU_STATE_IDLE,
    ST_REQ  = MAU_STATE_REQ,
    ST_DONE = MAU_STATE_DONE
  } mau_state_e;

  // Unsigned widths exist only for loads.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      FUNCT3_B, FUNCT3_H, FUNCT3_W: ok = 1'b1;
      FUNCT3_BU, FUNCT3_HU:         ok = ~is_store;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_aligner.sv
// Combinational load alignment: shifts the addressed byte lane down and
// sign- or zero-extends according to funct3.
module mem_load_aligner
  import mem_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      FUNCT3_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_BU: load_data = {24'h000000, shifted[7:0]};
      FUNCT3_HU: load_data = {16'h0000, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: runs one req/ack transaction per load/store and
// stalls the core meanwhile. Define MEM_ACCESS_TIMEOUT_EN to abort stuck requests.
module mem_access_unit
  import mem_defs::*;
`ifdef MEM_ACCESS_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        should_read_mem,
  input  logic        should_write_mem,
  input  logic [1:0]  mem_write_src,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] xmm_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault
);

  mau_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic        start, illegal, misaligned;
  logic [31:0] store_src;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;

  always_comb begin
    start = instr_valid & (should_read_mem | should_write_mem);

    misaligned = 1'b0;
    case (funct3)
      FUNCT3_H, FUNCT3_HU: misaligned = addr[0];
      FUNCT3_W:            misaligned = (addr[1:0] != 2'b00);
      default:             misaligned = 1'b0;
    endcase

    illegal = (should_read_mem & should_write_mem)
            | ~funct3_legal(funct3, should_write_mem)
            | (should_write_mem & (mem_write_src != MEM_WRITE_SRC_REG)
                                & (mem_write_src != MEM_WRITE_SRC_XMM))
            | misaligned;

    // Sub-word stores replicate the datum across lanes; strobes pick the lane.
    store_src = (mem_write_src == MEM_WRITE_SRC_XMM) ? xmm_data : reg_data;
    case (funct3)
      FUNCT3_B: begin
        lane_wdata = {4{store_src[7:0]}};
        lane_wstrb = 4'b0001 << addr[1:0];
      end
      FUNCT3_H: begin
        lane_wdata = {2{store_src[15:0]}};
        lane_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        lane_wdata = store_src;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    fault_d  = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (illegal) begin
            fault_d = 1'b1;
          end else begin
            state_d  = ST_REQ;
            addr_d   = addr;
            funct3_d = funct3;
            we_d     = should_write_mem;
            wdata_d  = should_write_mem ? lane_wdata : 32'h0;
            wstrb_d  = should_write_mem ? lane_wstrb : 4'b0000;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = ST_DONE;
`ifdef MEM_ACCESS_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'h0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign stall      = ((state_q == ST_IDLE) & start & ~illegal) | (state_q == ST_REQ);
  assign mem_req    = (state_q == ST_REQ);
  assign mem_we     = we_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign load_valid = (state_q == ST_DONE) & ~we_q;
  assign fault      = fault_q;

  mem_load_aligner u_aligner (
    .rdata     (rdata_q),
    .byte_off  (addr_q[1:0]),
    .funct3    (funct3_q),
    .load_data (load_data)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases then random transactions checked
// against a byte-level reference model. Honors MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, should_read_mem, should_write_mem;
  logic [1:0]  mem_write_src;
  logic [2:0]  funct3;
  logic [31:0] addr, reg_data, xmm_data;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, load_data;
  logic [3:0]  mem_wstrb;
  logic        mem_ack, load_valid, fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TO = 4;
  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
`else
  mem_access_unit dut (
`endif
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .should_read_mem(should_read_mem), .should_write_mem(should_write_mem),
    .mem_write_src(mem_write_src), .funct3(funct3), .addr(addr),
    .reg_data(reg_data), .xmm_data(xmm_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .load_data(load_data), .load_valid(load_valid),
    .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int f3_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit ref_illegal(input bit rd, input bit wr, input logic [1:0] src,
                                     input logic [2:0] f3, input logic [31:0] a);
    bit ok_f3;
    ok_f3 = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (rd && wr) return 1;
    if (!ok_f3) return 1;
    if (wr && !(src inside {2'd1, 2'd2})) return 1;
    if ((a % f3_size(f3)) != 0) return 1;
    return 0;
  endfunction

  // Gather the addressed bytes little-endian, then extend by value range.
  function automatic logic [31:0] ref_load(input logic [31:0] rdat, input logic [31:0] a,
                                           input logic [2:0] f3);
    int off, sz;
    longint v;
    off = int'(a % 4);
    sz  = f3_size(f3);
    v   = 0;
    for (int i = 0; i < sz; i++) v += longint'(rdat[8*(off+i) +: 8]) << (8*i);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz-1))) v -= (longint'(1) << (8*sz));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] d, input logic [31:0] a, input logic [2:0] f3,
                           output logic [31:0] wd, output logic [3:0] ws);
    int off, sz;
    off = int'(a % 4);
    sz  = f3_size(f3);
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = d[8*(i % sz) +: 8];
      ws[i]        = (i >= off) && (i < off + sz);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic access(input bit iv, input bit rd, input bit wr, input logic [1:0] src,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat,
                        input logic [31:0] rdv, input logic [31:0] xdv, input int ack_delay,
                        input string tag);
    bit start, ill;
    logic [31:0] exp_wd, exp_ld;
    logic [3:0]  exp_ws;
    start = iv && (rd || wr);
    ill   = start && ref_illegal(rd, wr, src, f3, a);
    exp_wd = 32'h0;
    exp_ws = 4'b0000;
    if (wr) ref_store((src == 2'd2) ? xdv : rdv, a, f3, exp_wd, exp_ws);
    exp_ld = ref_load(rdat, a, f3);

    instr_valid = iv; should_read_mem = rd; should_write_mem = wr;
    mem_write_src = src; funct3 = f3; addr = a; reg_data = rdv; xmm_data = xdv;
    #1;
    chk({tag, ".stall_issue"}, 32'(stall), 32'(start && !ill));
    step();
    instr_valid = 1'b0;
    addr = $urandom; reg_data = $urandom; xmm_data = $urandom; funct3 = 3'($urandom);
    #1;
    $display("txn %s iv=%0b rd=%0b wr=%0b src=%0d f3=%0d addr=0x%08h illegal=%0b ack_delay=%0d",
             tag, iv, rd, wr, src, f3, a, ill, ack_delay);
    if (!start || ill) begin
      chk({tag, ".fault"}, 32'(fault), 32'(ill));
      chk({tag, ".noreq"}, 32'(mem_req), 32'd0);
      chk({tag, ".nostall"}, 32'(stall), 32'd0);
      step(); #1;
      chk({tag, ".fault_clr"}, 32'(fault), 32'd0);
      chk({tag, ".noreq2"}, 32'(mem_req), 32'd0);
      return;
    end
    for (int k = 1; k <= ack_delay; k++) begin
      chk({tag, ".req"}, 32'(mem_req), 32'd1);
      chk({tag, ".we"}, 32'(mem_we), 32'(wr));
      chk({tag, ".maddr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, ".wstrb"}, 32'(mem_wstrb), 32'(exp_ws));
      if (wr) chk({tag, ".wdata"}, mem_wdata, exp_wd);
      chk({tag, ".stall_req"}, 32'(stall), 32'd1);
      chk({tag, ".lv_req"}, 32'(load_valid), 32'd0);
      chk({tag, ".fault_req"}, 32'(fault), 32'd0);
      if (k == ack_delay) begin
        mem_ack = 1'b1; mem_rdata = rdat;
      end
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
`ifdef MEM_ACCESS_TIMEOUT_EN
      if (k == TO && ack_delay > TO) begin
        chk({tag, ".to_fault"}, 32'(fault), 32'd1);
        chk({tag, ".to_req"}, 32'(mem_req), 32'd0);
        chk({tag, ".to_lv"}, 32'(load_valid), 32'd0);
        chk({tag, ".to_stall"}, 32'(stall), 32'd0);
        step(); #1;
        chk({tag, ".to_fault_clr"}, 32'(fault), 32'd0);
        return;
      end
`endif
    end
    chk({tag, ".done_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".done_lv"}, 32'(load_valid), 32'(rd));
    chk({tag, ".done_fault"}, 32'(fault), 32'd0);
    if (rd) chk({tag, ".ldata"}, load_data, exp_ld);
    step(); #1;
    chk({tag, ".idle_lv"}, 32'(load_valid), 32'd0);
    chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit rd, wr, iv;
    logic [31:0] a;
    int r;
    reset = 1'b1; instr_valid = 1'b0; should_read_mem = 1'b0; should_write_mem = 1'b0;
    mem_write_src = 2'd0; funct3 = 3'd0; addr = 32'h0; reg_data = 32'h0; xmm_data = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.load_data", load_data, 32'h0);
    chk("rst.load_valid", 32'(load_valid), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    step();

    access(1, 1, 0, 2'd0, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 3, "lw_104");
    access(1, 1, 0, 2'd0, 3'b000, 32'h203, 32'h80112233, 0, 0, 1, "lb_203");
    access(1, 1, 0, 2'd0, 3'b100, 32'h203, 32'h80112233, 0, 0, 2, "lbu_203");
    access(1, 1, 0, 2'd0, 3'b101, 32'h202, 32'h80112233, 0, 0, 1, "lhu_202");
    access(1, 0, 1, 2'd1, 3'b000, 32'h11, 32'h0, 32'h000000A5, 32'h12345678, 1, "sb_11");
    access(1, 0, 1, 2'd2, 3'b010, 32'h40, 32'h0, 32'h11111111, 32'h3F800000, 2, "sw_xmm");
    access(1, 0, 1, 2'd1, 3'b001, 32'h22, 32'h0, 32'hCAFEBEEF, 32'h0, 1, "sh_22");
    access(1, 1, 0, 2'd0, 3'b010, 32'h102, 32'h0, 0, 0, 1, "lw_mis");
    access(1, 0, 1, 2'd1, 3'b001, 32'h101, 32'h0, 0, 0, 1, "sh_mis");
    access(1, 1, 1, 2'd1, 3'b010, 32'h100, 32'h0, 0, 0, 1, "rd_wr");
    access(1, 0, 1, 2'd3, 3'b010, 32'h100, 32'h0, 0, 0, 1, "bad_src");
    access(1, 0, 1, 2'd1, 3'b100, 32'h100, 32'h0, 0, 0, 1, "sbu_bad");

    // Reset during the second REQ cycle, with a late ack afterwards.
    instr_valid = 1; should_read_mem = 1; should_write_mem = 0; funct3 = 3'b010; addr = 32'h300;
    step();
    instr_valid = 0; #1;
    chk("rstreq.req1", 32'(mem_req), 32'd1);
    step();
    reset = 1'b1; #1;
    chk("rstreq.req2", 32'(mem_req), 32'd1);
    step();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA; #1;
    chk("rstreq.req_drop", 32'(mem_req), 32'd0);
    chk("rstreq.stall", 32'(stall), 32'd0);
    chk("rstreq.lv", 32'(load_valid), 32'd0);
    step();
    mem_ack = 1'b0; #1;
    chk("rstreq.lv2", 32'(load_valid), 32'd0);
    chk("rstreq.req_idle", 32'(mem_req), 32'd0);
    chk("rstreq.fault", 32'(fault), 32'd0);
    $display("txn rst_mid_req done");

`ifdef MEM_ACCESS_TIMEOUT_EN
    access(1, 1, 0, 2'd0, 3'b010, 32'h500, 32'h12345678, 0, 0, 6, "timeout");
    access(1, 1, 0, 2'd0, 3'b010, 32'h504, 32'h87654321, 0, 0, 4, "ack_at_to");
`endif

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      rd = (r <= 4) || (r == 9);
      wr = (r >= 5);
      iv = ($urandom_range(0, 7) != 0);
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      access(iv, rd, wr, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a,
             $urandom, $urandom, $urandom, $urandom_range(1, 6), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
